// File: rtl/clkgen_pkg.sv
// Shared defaults for the clock-enable generator and its per-channel slices.
// Default divide is by 8: half-period of 4 cycles, the legacy processor/regfile rate.
package clkgen_pkg;
    localparam int CLKGEN_CNT_W    = 8;
    localparam int CLKGEN_DEF_HALF = 4;
    localparam int CLKGEN_MAX_CH   = 16;
endpackage

// File: rtl/clkgen_channel.sv
// One divided-clock channel: half-period counter, active/shadow half-period, registered clk_out and tick.
// Shadow half-periods are applied only at a toggle boundary, on disable, or on realign, so no runt pulses.
module clkgen_channel
    import clkgen_pkg::*;
#(
    parameter int CNT_W    = CLKGEN_CNT_W,
    parameter int DEF_HALF = CLKGEN_DEF_HALF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_realign,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_half,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_pending
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_boundary;

    // Half-period is never zero: zero writes are rejected upstream and DEF_HALF is nonzero.
    assign w_boundary = (r_cnt == r_half - 1'b1);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt     <= '0;
            r_half    <= CNT_W'(DEF_HALF);
            r_shadow  <= CNT_W'(DEF_HALF);
            r_pending <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (!i_en || i_realign) begin
                r_cnt     <= '0;
                r_clk_out <= 1'b0;
                r_tick    <= 1'b0;
                if (r_pending) begin
                    r_half <= r_shadow;
                end
                r_pending <= 1'b0;
            end else if (w_boundary) begin
                r_cnt     <= '0;
                r_clk_out <= ~r_clk_out;
                r_tick    <= ~r_clk_out;
                if (r_pending) begin
                    r_half <= r_shadow;
                end
                r_pending <= 1'b0;
            end else begin
                r_cnt  <= r_cnt + 1'b1;
                r_tick <= 1'b0;
            end
            // A write landing on a boundary/realign edge must survive as pending for the next one.
            if (i_wr) begin
                r_shadow  <= i_wr_half;
                r_pending <= 1'b1;
            end
        end
    end

    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;
    assign o_pending = r_pending;
endmodule

// File: rtl/clock_enable_gen.sv
// Bank of NUM_CH independently configurable divided clocks with tick strobes.
// Config writes are decoded here; rejected writes raise a one-cycle registered cfg_err.
module clock_enable_gen
    import clkgen_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CLKGEN_CNT_W,
    parameter int DEF_HALF = CLKGEN_DEF_HALF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              realign,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    localparam logic [4:0] LP_NUM_CH = 5'(NUM_CH);

    logic w_ch_ok;
    logic w_half_ok;
    logic w_cfg_ok;
    logic r_cfg_err;

    assign w_ch_ok   = ({1'b0, cfg_ch} < LP_NUM_CH);
    assign w_half_ok = (cfg_half != '0);
    assign w_cfg_ok  = cfg_we && w_ch_ok && w_half_ok;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= cfg_we && !w_cfg_ok;
        end
    end

    assign cfg_err = r_cfg_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_wr;
        assign w_wr = w_cfg_ok && (cfg_ch == 4'(g));

        clkgen_channel #(
            .CNT_W    (CNT_W),
            .DEF_HALF (DEF_HALF)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .i_en      (ch_en[g]),
            .i_realign (realign),
            .i_wr      (w_wr),
            .i_wr_half (cfg_half),
            .o_clk_out (clk_out[g]),
            .o_tick    (tick[g]),
            .o_pending (pending[g])
        );
    end
endmodule

// File: tb/tb_clock_enable_gen.sv
// Bench for clock_enable_gen: event-time reference model checked every cycle, directed scenarios, random traffic.
module tb_clock_enable_gen;
    localparam int NUM_CH   = 4;
    localparam int CNT_W    = 8;
    localparam int DEF_HALF = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] ch_en;
    logic              realign;
    logic              cfg_we;
    logic [3:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    clock_enable_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEF_HALF(DEF_HALF)) dut (
        .clock(clock), .reset(reset), .ch_en(ch_en), .realign(realign),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_half(cfg_half), .cfg_err(cfg_err),
        .clk_out(clk_out), .tick(tick), .pending(pending)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;
    int ecount = 0;

    // Reference model: each channel is described by the absolute edge of its next toggle.
    bit                m_valid = 1'b0;
    int                m_H[NUM_CH];
    int                m_S[NUM_CH];
    int                m_next[NUM_CH];
    logic [NUM_CH-1:0] m_pend, m_lvl, m_tick;
    logic              m_err;

    int last_rise[NUM_CH];
    int prev_rise[NUM_CH];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, ecount, act, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_H[i] = DEF_HALF; m_S[i] = DEF_HALF; m_next[i] = ecount + DEF_HALF;
                m_pend[i] = 1'b0; m_lvl[i] = 1'b0; m_tick[i] = 1'b0;
            end
            m_err   = 1'b0;
            m_valid = 1'b1;
        end else begin
            m_err = cfg_we && (cfg_half == '0 || int'(cfg_ch) >= NUM_CH);
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_en[i] || realign || ecount == m_next[i]) begin
                    if (m_pend[i]) m_H[i] = m_S[i];
                    m_pend[i] = 1'b0;
                    if (!ch_en[i] || realign) m_lvl[i] = 1'b0;
                    else                      m_lvl[i] = ~m_lvl[i];
                    m_tick[i] = m_lvl[i] && ch_en[i] && !realign;
                    m_next[i] = ecount + m_H[i];
                end else begin
                    m_tick[i] = 1'b0;
                end
            end
            if (cfg_we && cfg_half != '0 && int'(cfg_ch) < NUM_CH) begin
                m_S[int'(cfg_ch)]    = int'(cfg_half);
                m_pend[int'(cfg_ch)] = 1'b1;
            end
        end
    endtask

    task automatic compare();
        if (m_valid) begin
            chk("clk_out", 32'(clk_out), 32'(m_lvl));
            chk("tick",    32'(tick),    32'(m_tick));
            chk("pending", 32'(pending), 32'(m_pend));
            chk("cfg_err", 32'(cfg_err), 32'(m_err));
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        ecount++;
        model_step();
        #1;
        compare();
        for (int i = 0; i < NUM_CH; i++) begin
            if (tick[i] === 1'b1) begin
                prev_rise[i] = last_rise[i];
                last_rise[i] = ecount;
            end
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wr(input int ch, input int half);
        cfg_we = 1'b1; cfg_ch = 4'(ch); cfg_half = CNT_W'(half);
        cycle();
        cfg_we = 1'b0;
    endtask

    initial begin
        int rst_edge;
        int first_off[NUM_CH];
        bit found;
        reset = 1'b1; ch_en = '1; realign = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_half = '0;
        for (int i = 0; i < NUM_CH; i++) begin last_rise[i] = 0; prev_rise[i] = 0; end

        // Reset values and default divide-by-8 from all channels.
        cycles(3);
        chk("rst clk_out", 32'(clk_out), 32'h0);
        chk("rst tick",    32'(tick),    32'h0);
        chk("rst pending", 32'(pending), 32'h0);
        chk("rst cfg_err", 32'(cfg_err), 32'h0);
        rst_edge = ecount;
        reset = 1'b0;
        cycles(3);
        chk("pre-rise clk_out", 32'(clk_out), 32'h0);
        cycle();
        chk("first rise clk_out", 32'(clk_out), 32'hF);
        chk("first rise tick",    32'(tick),    32'hF);
        cycle();
        chk("tick one cycle", 32'(tick), 32'h0);
        cycles(15);
        for (int i = 0; i < NUM_CH; i++) begin
            chk($sformatf("default period ch%0d", i), 32'(last_rise[i] - prev_rise[i]), 32'd8);
            chk($sformatf("third rise ch%0d", i), 32'(last_rise[i] - rst_edge), 32'd20);
        end

        // Mid-half-period write to ch1 is held until its next toggle, then gives period 6.
        cycles(2);
        wr(1, 3);
        chk("ch1 pending held", 32'(pending), 32'h2);
        cycle();
        chk("ch1 applied at toggle", 32'(pending), 32'h0);
        cycles(24);
        chk("ch1 period 6", 32'(last_rise[1] - prev_rise[1]), 32'd6);
        for (int i = 0; i < NUM_CH; i++)
            if (i != 1) chk($sformatf("ch%0d period 8", i), 32'(last_rise[i] - prev_rise[i]), 32'd8);

        // Rejected writes: zero half-period and out-of-range channel.
        wr(2, 0);
        chk("err half0 pulse", 32'(cfg_err), 32'h1);
        chk("err half0 no pending", 32'(pending), 32'h0);
        cycle();
        chk("err half0 one cycle", 32'(cfg_err), 32'h0);
        wr(7, 5);
        chk("err ch7 pulse", 32'(cfg_err), 32'h1);
        cycle();
        chk("err ch7 one cycle", 32'(cfg_err), 32'h0);
        chk("err ch7 no pending", 32'(pending), 32'h0);

        // Write on ch0's exact boundary edge, then overwrite: old half persists once, then period 4.
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (m_next[0] == ecount + 1) found = 1'b1;
            else cycle();
        end
        chk("boundary search", 32'(found), 32'h1);
        wr(0, 6);
        chk("boundary write pending", 32'(pending[0]), 32'h1);
        wr(0, 2);
        cycles(2);
        chk("overwrite still pending", 32'(pending[0]), 32'h1);
        cycle();
        chk("overwrite applied", 32'(pending[0]), 32'h0);
        cycles(16);
        chk("ch0 period 4", 32'(last_rise[0] - prev_rise[0]), 32'd4);

        // Realign with halves 2/3/5/4.
        wr(2, 5);
        cycles(20);
        chk("halves settled", 32'(pending), 32'h0);
        realign = 1'b1;
        cycle();
        realign = 1'b0;
        chk("realign clk_out", 32'(clk_out), 32'h0);
        chk("realign tick",    32'(tick),    32'h0);
        for (int i = 0; i < NUM_CH; i++) first_off[i] = 0;
        for (int k = 1; k <= 6; k++) begin
            cycle();
            for (int i = 0; i < NUM_CH; i++) if (tick[i] === 1'b1 && first_off[i] == 0) first_off[i] = k;
        end
        chk("realign rise ch0", 32'(first_off[0]), 32'd2);
        chk("realign rise ch1", 32'(first_off[1]), 32'd3);
        chk("realign rise ch2", 32'(first_off[2]), 32'd5);
        chk("realign rise ch3", 32'(first_off[3]), 32'd4);

        // Reset with ch3 pending discards the shadow and restores DEF_HALF.
        cycle();
        wr(3, 7);
        chk("ch3 pending before reset", 32'(pending[3]), 32'h1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("mid reset clk_out", 32'(clk_out), 32'h0);
        chk("mid reset tick",    32'(tick),    32'h0);
        chk("mid reset pending", 32'(pending), 32'h0);
        chk("mid reset cfg_err", 32'(cfg_err), 32'h0);
        cycles(4);
        chk("post reset rise", 32'(clk_out), 32'hF);
        cycles(4);
        chk("post reset fall", 32'(clk_out), 32'h0);

        // Disable applies a pending half immediately; H=1 divides by 2 from the first enabled edge.
        wr(2, 1);
        ch_en = 4'b1011;
        cycle();
        ch_en = 4'b1111;
        chk("disable applies pending", 32'(pending[2]), 32'h0);
        chk("disable clears clk_out", 32'(clk_out[2]), 32'h0);
        cycle();
        chk("div2 rise", 32'({clk_out[2], tick[2]}), 32'h3);
        cycle();
        chk("div2 fall", 32'({clk_out[2], tick[2]}), 32'h0);

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            reset   = ($urandom_range(0, 299) == 0);
            realign = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0)
                for (int i = 0; i < NUM_CH; i++) ch_en[i] = ($urandom_range(0, 3) != 0);
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_ch   = 4'($urandom_range(0, 7));
            cfg_half = CNT_W'($urandom_range(0, 6));
            cycle();
        end
        reset = 1'b0; realign = 1'b0; cfg_we = 1'b0; ch_en = '1;
        cycles(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
